// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Control end of the ID->EX interface of the pipeline. Every cycle it decides
//   whether the ID/EX register loads the decoded instruction or takes a bubble.
//   It also drives the PC and IF/ID enables and produces the forwarding selects
//   that travel with each instruction into EX. A 3-slot scoreboard (EX, MEM, WB)
//   tracks the destination registers still in flight. A RUN/STALL/FLUSH state
//   machine sequences load-use stalls and branch flushes, and two saturating
//   counters record stall and flush cycles.
//
// Parameters:
//   FLUSH_CYCLES  bubble cycles inserted after a taken branch/jump (1..7)
//   CNT_W         width of the performance counters
//
// Ports:
//   clk_HZ          in   clock
//   rst_n_HZ        in   asynchronous active-low reset
//   Rs1_addr_HZ     in   rs1 of the ID instruction
//   Rs2_addr_HZ     in   rs2 of the ID instruction
//   Rs1_used_HZ     in   ID instruction reads rs1
//   Rs2_used_HZ     in   ID instruction reads rs2
//   Rd_addr_HZ      in   rd of the ID instruction
//   RegWrite_HZ     in   ID instruction writes rd
//   MemtoReg_HZ     in   ID instruction's MemtoReg (2'b01 = load)
//   Taken_EX_HZ     in   branch taken / jump resolving in EX
//   PC_en_HZ        out  PC update enable
//   en_IFID_HZ      out  IF/ID load enable
//   flush_IFID_HZ   out  IF/ID loads a NOP
//   en_IDEX_HZ      out  ID/EX load enable
//   bubble_IDEX_HZ  out  ID/EX loads all-zero control
//   Fwd_A_HZ        out  operand-A select for the EX instruction (00 RF, 01 WB, 10 MEM)
//   Fwd_B_HZ        out  operand-B select, same encoding
//   stall_cnt_HZ    out  load-use stall cycle count (saturating)
//   flush_cnt_HZ    out  flush cycle count (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk_HZ,
  input  logic             rst_n_HZ,
  input  logic [4:0]       Rs1_addr_HZ,
  input  logic [4:0]       Rs2_addr_HZ,
  input  logic             Rs1_used_HZ,
  input  logic             Rs2_used_HZ,
  input  logic [4:0]       Rd_addr_HZ,
  input  logic             RegWrite_HZ,
  input  logic [1:0]       MemtoReg_HZ,
  input  logic             Taken_EX_HZ,
  output logic             PC_en_HZ,
  output logic             en_IFID_HZ,
  output logic             flush_IFID_HZ,
  output logic             en_IDEX_HZ,
  output logic             bubble_IDEX_HZ,
  output logic [1:0]       Fwd_A_HZ,
  output logic [1:0]       Fwd_B_HZ,
  output logic [CNT_W-1:0] stall_cnt_HZ,
  output logic [CNT_W-1:0] flush_cnt_HZ
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       isload;
  } slot_t;

  // Number of FLUSH-state cycles that follow the cycle in which the branch
  // resolves; zero means the single flush cycle happens in RUN itself.
  localparam logic [2:0] LP_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  localparam logic [1:0] LP_FWD_RF  = 2'b00;
  localparam logic [1:0] LP_FWD_WB  = 2'b01;
  localparam logic [1:0] LP_FWD_MEM = 2'b10;

  state_t     r_state;
  logic [2:0] r_flush_left;

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic  w_load_use;
  logic  w_stall;
  logic  w_pc_en;
  logic  w_en_ifid;
  logic  w_flush_ifid;
  logic  w_en_idex;
  logic  w_bubble;
  logic  w_ex_a;
  logic  w_ex_b;
  logic  w_mem_a;
  logic  w_mem_b;
  logic  [1:0] w_fwd_a;
  logic  [1:0] w_fwd_b;
  slot_t w_id_slot;

  // A slot only matters if it really writes a nonzero register that the ID
  // instruction actually reads.
  function automatic logic slotMatch(input slot_t s, input logic [4:0] rs,
                                     input logic used);
    return s.valid & s.regwrite & (s.rd == rs) & (rs != 5'd0) & used;
  endfunction

  assign w_ex_a  = slotMatch(r_ex,  Rs1_addr_HZ, Rs1_used_HZ);
  assign w_ex_b  = slotMatch(r_ex,  Rs2_addr_HZ, Rs2_used_HZ);
  assign w_mem_a = slotMatch(r_mem, Rs1_addr_HZ, Rs1_used_HZ);
  assign w_mem_b = slotMatch(r_mem, Rs2_addr_HZ, Rs2_used_HZ);

  assign w_load_use = r_ex.isload & (w_ex_a | w_ex_b);

  // The youngest producer wins: one in EX now will be in MEM when the ID
  // instruction reaches EX. A producer in WB is covered by regfile write-through.
  assign w_fwd_a = w_ex_a ? LP_FWD_MEM : (w_mem_a ? LP_FWD_WB : LP_FWD_RF);
  assign w_fwd_b = w_ex_b ? LP_FWD_MEM : (w_mem_b ? LP_FWD_WB : LP_FWD_RF);

  assign w_id_slot = '{valid:    1'b1,
                       rd:       Rd_addr_HZ,
                       regwrite: RegWrite_HZ,
                       isload:   (MemtoReg_HZ == 2'b01)};

  // Pipeline control. A taken branch beats everything; load-use stalls are
  // only raised from RUN, since STALL always follows a bubble and EX is empty.
  always_comb begin
    w_pc_en      = 1'b1;
    w_en_ifid    = 1'b1;
    w_flush_ifid = 1'b0;
    w_en_idex    = 1'b1;
    w_bubble     = 1'b0;
    w_stall      = 1'b0;
    if (Taken_EX_HZ) begin
      w_flush_ifid = 1'b1;
      w_bubble     = 1'b1;
    end else if (r_state == S_RUN && w_load_use) begin
      w_pc_en   = 1'b0;
      w_en_ifid = 1'b0;
      w_bubble  = 1'b1;
      w_stall   = 1'b1;
    end else if (r_state == S_FLUSH) begin
      w_flush_ifid = 1'b1;
      w_bubble     = 1'b1;
    end
  end

  // RUN/STALL/FLUSH sequencing. r_flush_left counts the FLUSH-state cycles
  // still to come, including the current one.
  always_ff @(posedge clk_HZ or negedge rst_n_HZ) begin
    if (!rst_n_HZ) begin
      r_state      <= S_RUN;
      r_flush_left <= 3'd0;
    end else if (Taken_EX_HZ) begin
      r_flush_left <= LP_FLUSH_RELOAD;
      r_state      <= (LP_FLUSH_RELOAD == 3'd0) ? S_RUN : S_FLUSH;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_load_use) r_state <= S_STALL;
        end
        S_STALL: begin
          r_state <= S_RUN;
        end
        S_FLUSH: begin
          r_flush_left <= r_flush_left - 3'd1;
          if (r_flush_left <= 3'd1) r_state <= S_RUN;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  // Scoreboard shift and forwarding-select registers; both advance every
  // cycle, stalls included, so a bubble marks the EX slot empty.
  always_ff @(posedge clk_HZ or negedge rst_n_HZ) begin
    if (!rst_n_HZ) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_fwd_a <= LP_FWD_RF;
      r_fwd_b <= LP_FWD_RF;
    end else begin
      r_ex  <= w_bubble ? slot_t'('0) : w_id_slot;
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_bubble) begin
        r_fwd_a <= LP_FWD_RF;
        r_fwd_b <= LP_FWD_RF;
      end else if (w_en_idex) begin
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_HZ or negedge rst_n_HZ) begin
    if (!rst_n_HZ) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_ifid && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign PC_en_HZ       = w_pc_en;
  assign en_IFID_HZ     = w_en_ifid;
  assign flush_IFID_HZ  = w_flush_ifid;
  assign en_IDEX_HZ     = w_en_idex;
  assign bubble_IDEX_HZ = w_bubble;
  assign Fwd_A_HZ       = r_fwd_a;
  assign Fwd_B_HZ       = r_fwd_b;
  assign stall_cnt_HZ   = r_stall_cnt;
  assign flush_cnt_HZ   = r_flush_cnt;

  // The WB slot is kept for completeness of the in-flight picture; nothing
  // forwards from it because the regfile writes through.
  logic w_wb_unused;
  assign w_wb_unused = ^r_wb;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. Each stimulus cycle pushes its hand-computed
// expected outputs onto a queue; a monitor on the falling edge pops and
// compares whatever the DUT is presenting that cycle.
// Expected ctrl vector = {PC_en, en_IFID, flush_IFID, en_IDEX, bubble_IDEX}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;

  localparam logic [4:0] C_PASS  = 5'b11010;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11111;

  logic             clk_HZ = 1'b0;
  logic             rst_n_HZ;
  logic [4:0]       Rs1_addr_HZ;
  logic [4:0]       Rs2_addr_HZ;
  logic             Rs1_used_HZ;
  logic             Rs2_used_HZ;
  logic [4:0]       Rd_addr_HZ;
  logic             RegWrite_HZ;
  logic [1:0]       MemtoReg_HZ;
  logic             Taken_EX_HZ;
  logic             PC_en_HZ;
  logic             en_IFID_HZ;
  logic             flush_IFID_HZ;
  logic             en_IDEX_HZ;
  logic             bubble_IDEX_HZ;
  logic [1:0]       Fwd_A_HZ;
  logic [1:0]       Fwd_B_HZ;
  logic [CNT_W-1:0] stall_cnt_HZ;
  logic [CNT_W-1:0] flush_cnt_HZ;

  typedef struct {
    string            name;
    logic [4:0]       ctrl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk_HZ        (clk_HZ),
    .rst_n_HZ      (rst_n_HZ),
    .Rs1_addr_HZ   (Rs1_addr_HZ),
    .Rs2_addr_HZ   (Rs2_addr_HZ),
    .Rs1_used_HZ   (Rs1_used_HZ),
    .Rs2_used_HZ   (Rs2_used_HZ),
    .Rd_addr_HZ    (Rd_addr_HZ),
    .RegWrite_HZ   (RegWrite_HZ),
    .MemtoReg_HZ   (MemtoReg_HZ),
    .Taken_EX_HZ   (Taken_EX_HZ),
    .PC_en_HZ      (PC_en_HZ),
    .en_IFID_HZ    (en_IFID_HZ),
    .flush_IFID_HZ (flush_IFID_HZ),
    .en_IDEX_HZ    (en_IDEX_HZ),
    .bubble_IDEX_HZ(bubble_IDEX_HZ),
    .Fwd_A_HZ      (Fwd_A_HZ),
    .Fwd_B_HZ      (Fwd_B_HZ),
    .stall_cnt_HZ  (stall_cnt_HZ),
    .flush_cnt_HZ  (flush_cnt_HZ)
  );

  always #5 clk_HZ = ~clk_HZ;

  // Drive one cycle of ID inputs just after the rising edge and queue the
  // outputs expected for that same cycle.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic rw,
                               input logic [1:0] mtr, input logic taken,
                               input logic [4:0] ctrl, input logic [1:0] fa,
                               input logic [1:0] fb, input int sc, input int fc);
    exp_t e;
    @(posedge clk_HZ);
    #1;
    rst_n_HZ    = rst;
    Rs1_addr_HZ = rs1;
    Rs1_used_HZ = u1;
    Rs2_addr_HZ = rs2;
    Rs2_used_HZ = u2;
    Rd_addr_HZ  = rd;
    RegWrite_HZ = rw;
    MemtoReg_HZ = mtr;
    Taken_EX_HZ = taken;
    e.name = name;
    e.ctrl = ctrl;
    e.fa   = fa;
    e.fb   = fb;
    e.sc   = CNT_W'(sc);
    e.fc   = CNT_W'(fc);
    expQ.push_back(e);
  endtask

  // A cycle with a NOP (reads nothing, writes nothing) in ID.
  task automatic nopCycle(input string name, input logic taken,
                          input logic [4:0] ctrl, input logic [1:0] fa,
                          input logic [1:0] fb, input int sc, input int fc);
    applyStimulus(name, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00,
                  taken, ctrl, fa, fb, sc, fc);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [4:0] act;
    act = {PC_en_HZ, en_IFID_HZ, flush_IFID_HZ, en_IDEX_HZ, bubble_IDEX_HZ};
    testsRun++;
    if (act !== e.ctrl || Fwd_A_HZ !== e.fa || Fwd_B_HZ !== e.fb ||
        stall_cnt_HZ !== e.sc || flush_cnt_HZ !== e.fc) begin
      testsFailed++;
      $display("[TB] FAIL %s: got ctrl=%b fa=%b fb=%b sc=%0d fc=%0d, expected ctrl=%b fa=%b fb=%b sc=%0d fc=%0d",
               e.name, act, Fwd_A_HZ, Fwd_B_HZ, stall_cnt_HZ, flush_cnt_HZ,
               e.ctrl, e.fa, e.fb, e.sc, e.fc);
    end
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs; compare
  // against the oldest queued expectation.
  always @(negedge clk_HZ) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_HZ    = 1'b0;
    Rs1_addr_HZ = '0;
    Rs2_addr_HZ = '0;
    Rs1_used_HZ = 1'b0;
    Rs2_used_HZ = 1'b0;
    Rd_addr_HZ  = '0;
    RegWrite_HZ = 1'b0;
    MemtoReg_HZ = 2'b00;
    Taken_EX_HZ = 1'b0;

    // Reset values
    applyStimulus("reset_hold", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 0, 0);
    nopCycle("reset_release", 1'b0, C_PASS, 2'b00, 2'b00, 0, 0);

    // Load-use on rs1: lw x5 ; add x6,x5,x7
    applyStimulus("lu_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01,
                  1'b0, C_PASS, 2'b00, 2'b00, 0, 0);
    applyStimulus("lu_stall", 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 2'b00,
                  1'b0, C_STALL, 2'b00, 2'b00, 0, 0);
    applyStimulus("lu_after", 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    nopCycle("lu_fwd_wb", 1'b0, C_PASS, 2'b01, 2'b00, 1, 0);

    // Back-to-back ALU dependence: add x3 ; sub x4,x3,x3
    applyStimulus("alu_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    applyStimulus("alu_sub", 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    nopCycle("alu_fwd_mem", 1'b0, C_PASS, 2'b10, 2'b10, 1, 0);

    // One unrelated instruction between producer and consumer
    applyStimulus("gap_add", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    applyStimulus("gap_x9", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    applyStimulus("gap_sub", 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    nopCycle("gap_fwd_wb", 1'b0, C_PASS, 2'b01, 2'b01, 1, 0);

    // Producer x9 now sits in WB: no forwarding from there
    applyStimulus("wb_reader", 1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);

    // lw x0 followed by a reader of x0: no stall, no forwarding
    applyStimulus("x0_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    applyStimulus("x0_reader", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);

    // lw x8 followed by an instruction that has rs2=8 but does not use it
    applyStimulus("unused_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 2'b01,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    applyStimulus("unused_rd", 1'b1, 5'd1, 1'b1, 5'd8, 1'b0, 5'd12, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    nopCycle("unused_fwd", 1'b0, C_PASS, 2'b00, 2'b00, 1, 0);

    // Branch flush: two bubble cycles
    nopCycle("br_taken", 1'b1, C_FLUSH, 2'b00, 2'b00, 1, 0);
    nopCycle("br_flush2", 1'b0, C_FLUSH, 2'b00, 2'b00, 1, 1);
    nopCycle("br_done", 1'b0, C_PASS, 2'b00, 2'b00, 1, 2);

    // Branch and load-use in the same cycle: flush wins
    applyStimulus("both_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 2);
    applyStimulus("both_taken", 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 2'b00,
                  1'b1, C_FLUSH, 2'b00, 2'b00, 1, 2);
    nopCycle("both_flush2", 1'b0, C_FLUSH, 2'b00, 2'b00, 1, 3);
    nopCycle("both_done", 1'b0, C_PASS, 2'b00, 2'b00, 1, 4);

    // Reset in the middle of a flush
    nopCycle("rst_taken", 1'b1, C_FLUSH, 2'b00, 2'b00, 1, 4);
    applyStimulus("rst_mid_flush", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 0, 0);

    // After release: lw x7 ; add x6,x1,x7 -> load-use through rs2
    applyStimulus("rst_after_lw", 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'b01,
                  1'b0, C_PASS, 2'b00, 2'b00, 0, 0);
    applyStimulus("lu2_stall", 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 2'b00,
                  1'b0, C_STALL, 2'b00, 2'b00, 0, 0);
    applyStimulus("lu2_after", 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 2'b00,
                  1'b0, C_PASS, 2'b00, 2'b00, 1, 0);
    nopCycle("lu2_fwd_b", 1'b0, C_PASS, 2'b00, 2'b01, 1, 0);

    // Taken held high: every cycle flushes, counter saturates at 15
    for (int k = 0; k < 18; k++) begin
      nopCycle($sformatf("sat_%0d", k), 1'b1, C_FLUSH, 2'b00, 2'b00, 1,
               (k > 15) ? 15 : k);
    end
    nopCycle("sat_tail", 1'b0, C_FLUSH, 2'b00, 2'b00, 1, 15);
    nopCycle("sat_run", 1'b0, C_PASS, 2'b00, 2'b00, 1, 15);

    // Let the monitor drain, bounded
    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk_HZ);
    #1;
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
